// File: rtl/freq_hop_nco.sv
// Frequency-hopping NCO: 8-entry tuning table, IDLE/ARM/RUN sequencer.
// Define FREQ_HOP_PHASE_RESET_EN to zero the accumulator on every hop/arm.
module freq_hop_nco #(
  parameter int ACC_W = 32,
  parameter int PH_W  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       addr,
  input  logic             en,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [ACC_W-1:0] wr_data,
  output logic [PH_W-1:0]  phase,
  output logic             valid,
  output logic             hop,
  output logic [2:0]       chan
);

  if (PH_W > ACC_W) begin : g_bad_param
    $error("PH_W must not exceed ACC_W");
  end

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ACC_W-1:0] tbl [8];
  logic [ACC_W-1:0] ftw_rd;
  logic [ACC_W-1:0] ftw_q;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nx;
  logic [2:0]       addr_q;
  logic             load;
  logic             adv;
  logic             upd;

  // Reads see the pre-write value since the write lands via <=.
  assign ftw_rd = tbl[addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        tbl[i] <= '0;
      end
    end else if (wr_en) begin
      tbl[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    adv      = 1'b0;
    unique case (state)
      IDLE: begin
        if (en) state_nx = ARM;
      end
      ARM: begin
        if (en) begin
          state_nx = RUN;
          load     = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      RUN: begin
        if (!en) begin
          state_nx = IDLE;
        end else begin
          adv  = 1'b1;
          load = (addr != addr_q);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef FREQ_HOP_PHASE_RESET_EN
  // Phase-coherent restart: a load edge zeroes acc.
  always_comb begin
    acc_nx = load ? '0 : acc + ftw_q;
    upd    = load | adv;
  end
`else
  // Phase-continuous: a hop edge still adds the outgoing FTW.
  always_comb begin
    acc_nx = acc + ftw_q;
    upd    = adv;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      ftw_q  <= '0;
      addr_q <= '0;
      phase  <= '0;
      hop    <= 1'b0;
      chan   <= '0;
    end else begin
      state <= state_nx;
      hop   <= load;
      if (load) begin
        ftw_q  <= ftw_rd;
        chan   <= addr;
        addr_q <= addr;
      end
      if (upd) begin
        acc   <= acc_nx;
        phase <= acc_nx[ACC_W-1 -: PH_W];
      end
    end
  end

  assign valid = (state == RUN);

endmodule
